// File: rtl/mac_window_feeder.sv
// mac_window_feeder: buffers IN_DIM-element vectors in a small FIFO and places each one into an
// OUT_DIM-element output window at a sliding element offset that advances by STRIDE per window.
// Optional build macro MAC_WINDOW_HOLD_EN: lanes outside the placed slice keep the previous
// window (cleared on start); when undefined those lanes read as zero.
module mac_window_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_DIM     = 3,
  parameter int unsigned OUT_DIM    = 8,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [IN_DIM*DATA_WIDTH-1:0]      in_vector,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_DIM*DATA_WIDTH-1:0]     out_vector,
  output logic [$clog2(OUT_DIM):0]          out_offset,
  output logic                              busy,
  output logic                              all_done
);

  localparam int unsigned InW    = IN_DIM * DATA_WIDTH;
  localparam int unsigned OutW   = OUT_DIM * DATA_WIDTH;
  localparam int unsigned OffW   = $clog2(OUT_DIM) + 1;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned MaxOff = OUT_DIM - IN_DIM;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [InW-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [OffW-1:0]   off_q, off_d;
  logic [OutW-1:0]   out_vector_q;
  logic [OffW-1:0]   out_offset_q;
  logic              out_valid_q;
  logic              push, pop;
  logic [31:0]       shamt;
  logic [OutW-1:0]   head_ext, lane_mask, placed, win_d;

  assign in_ready   = (state_q == StRun) && (count_q < CntW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (count_q != '0) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_vector = out_vector_q;
  assign out_offset = out_offset_q;
  assign busy       = (state_q != StIdle);
  assign all_done   = (state_q == StDone);

  // FIFO storage; contents need no reset since count_q gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_vector;
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Next window offset: restart at zero on start, advance by STRIDE per pop, wrap past the end
  always_comb begin
    off_d = off_q;
    if (state_q == StIdle && start) begin
      off_d = '0;
    end else if (pop) begin
      if (int'(off_q) + STRIDE > MaxOff) off_d = '0;
      else                              off_d = off_q + OffW'(STRIDE);
    end
  end

  // Place the FIFO head at the current offset within the window
  always_comb begin
    shamt                = 32'(off_q) * DATA_WIDTH;
    head_ext             = '0;
    head_ext[InW-1:0]    = mem_q[rd_ptr_q];
    lane_mask            = '0;
    lane_mask[InW-1:0]   = '1;
    placed               = head_ext << shamt;
`ifdef MAC_WINDOW_HOLD_EN
    win_d = (out_vector_q & ~(lane_mask << shamt)) | placed;
`else
    win_d = placed;
`endif
  end

  // Run-control FSM together with the registered output window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      off_q        <= '0;
      out_vector_q <= '0;
      out_offset_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      off_q <= off_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
`ifdef MAC_WINDOW_HOLD_EN
            out_vector_q <= '0;
`endif
          end
        end
        StRun:   if (push && in_last) state_q <= StDrain;
        StDrain: if (count_q == '0 && !out_valid_q) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (pop) begin
        out_vector_q <= win_d;
        out_offset_q <= off_q;
        out_valid_q  <= 1'b1;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_window_feeder.sv
// Self-checking bench for mac_window_feeder: directed scenarios plus randomized runs, all output
// windows compared against a queue-based reference model of placement and offset stepping.
module tb_mac_window_feeder;

  localparam int unsigned DW     = 8;
  localparam int unsigned InDim  = 3;
  localparam int unsigned OutDim = 8;
  localparam int unsigned Stride = 2;
  localparam int unsigned Depth  = 4;
  localparam int unsigned InW    = InDim * DW;
  localparam int unsigned OutW   = OutDim * DW;
  localparam int unsigned OffW   = $clog2(OutDim) + 1;
`ifdef MAC_WINDOW_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [InW-1:0]  in_vector = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OutW-1:0] out_vector;
  logic [OffW-1:0] out_offset;
  logic            busy;
  logic            all_done;

  mac_window_feeder #(
    .DATA_WIDTH (DW),
    .IN_DIM     (InDim),
    .OUT_DIM    (OutDim),
    .STRIDE     (Stride),
    .DEPTH      (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .out_offset (out_offset),
    .busy       (busy),
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expected windows in acceptance order
  logic [OutW-1:0] exp_win_q [$];
  int              exp_off_q [$];
  int              model_off = 0;
  logic [OutW-1:0] model_win = '0;
  logic [63:0]     obs_win [$];
  int              obs_off [$];
  int              acc_cnt = 0;
  int              done_cnt = 0;
  bit              prev_stall = 1'b0;
  logic [OutW-1:0] prev_vec = '0;
  logic [OffW-1:0] prev_off = '0;
  bit              rnd_rdy = 1'b0;

  // Monitor, sampling mid-cycle
  always @(negedge clk) begin
    logic [OutW-1:0] ext, msk, exp_w;
    if (rst) begin
      exp_win_q.delete();
      exp_off_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (all_done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_vector", out_vector, prev_vec);
        check("stall_offset", 64'(out_offset), 64'(prev_off));
      end
      if (start && !busy) begin
        model_off = 0;
        model_win = '0;
      end
      if (in_valid && in_ready) begin
        ext = '0;
        ext[InW-1:0] = in_vector;
        msk = '0;
        msk[InW-1:0] = '1;
        ext = ext << (model_off * DW);
        msk = msk << (model_off * DW);
        exp_w = Hold ? ((model_win & ~msk) | ext) : ext;
        model_win = exp_w;
        exp_win_q.push_back(exp_w);
        exp_off_q.push_back(model_off);
        model_off = (model_off + Stride > OutDim - InDim) ? 0 : model_off + Stride;
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        obs_win.push_back(out_vector);
        obs_off.push_back(int'(out_offset));
        if (exp_win_q.size() == 0) begin
          check("window_expected", 64'(exp_win_q.size()), 64'd1);
        end else begin
          check("window_value", out_vector, exp_win_q.pop_front());
          check("window_offset", 64'(out_offset), 64'(exp_off_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vector;
      prev_off   = out_offset;
    end
  end

  // Random downstream backpressure when enabled
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [InW-1:0] v, input logic last, input bit rnd_start);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_vector = v;
    in_last   = last;
    for (int i = 0; i < 400 && !ok; i++) begin
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("run_finished", 64'(idle), 64'd1);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("model_drained", 64'(exp_win_q.size()), 64'd0);
    tick();
  endtask

  task automatic clear_obs();
    obs_win.delete();
    obs_off.delete();
  endtask

  initial begin
    int exp_offs [4] = '{0, 2, 4, 0};
    int a0;
    int len;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    check("rst_out_vector", out_vector, 64'd0);
    check("rst_out_offset", 64'(out_offset), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Same vector four times, stride 2: offsets 0,2,4,0
    clear_obs();
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) send(24'h030201, 1'(i == 3), 1'b0);
    wait_done();
    check("basic_count", 64'(obs_win.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("basic_offset", 64'(obs_off[i]), 64'(exp_offs[i]));
    check("basic_second_win", obs_win[1], 64'h0000000302010000);

    // Start accepted on the cycle after DONE; lane-hold behaviour on the second window
    clear_obs();
    do_start();
    send(24'h030201, 1'b0, 1'b0);
    send(24'h060504, 1'b1, 1'b0);
    wait_done();
    check("hold_count", 64'(obs_win.size()), 64'd2);
    check("hold_second_win", obs_win[1], Hold ? 64'h0000000605040201 : 64'h0000000605040000);

    // Backpressure: 4 FIFO entries + 1 output register, then in_ready drops
    clear_obs();
    out_ready = 1'b0;
    a0 = acc_cnt;
    do_start();
    for (int i = 0; i < 5; i++) send(InW'(32'h101010 * (i + 1)), 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_vector = 24'h606060;
    in_last   = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_accepted", 64'(acc_cnt - a0), 64'd5);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_head_win", out_vector, 64'h0000000000101010);
    tick();
    out_ready = 1'b1;
    send(24'h606060, 1'b1, 1'b0);
    wait_done();
    check("bp_count", 64'(obs_win.size()), 64'd6);

    // Steady stream with continuous out_ready
    clear_obs();
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 10; i++) send(InW'($urandom()), 1'(i == 9), 1'b0);
    wait_done();
    check("stream_count", 64'(obs_win.size()), 64'd10);

    // Reset mid-run with entries queued
    clear_obs();
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send(InW'($urandom()), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_vector", out_vector, 64'd0);
    check("mid_rst_out_offset", 64'(out_offset), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_no_windows", 64'(obs_win.size()), 64'd0);
    check("post_rst_idle", 64'(busy), 64'd0);
    do_start();
    send(24'hAABBCC, 1'b1, 1'b0);
    wait_done();
    check("restart_count", 64'(obs_win.size()), 64'd1);
    check("restart_offset", 64'(obs_off[0]), 64'd0);

    // Randomized runs with random backpressure and stray start pulses
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      len = int'($urandom_range(3, 10));
      rnd_rdy = 1'b1;
      do_start();
      for (int i = 0; i < len; i++) begin
        send(InW'($urandom()), 1'(i == len - 1), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_done();
      rnd_rdy = 1'b0;
      tick();
      out_ready = 1'b1;
      check("rand_count", 64'(obs_win.size()), 64'(len));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
